// File: rtl/csr_file.sv
// Control/status register file for the write-back stage: CSR access, exception
// entry, ertn return, constant timer and interrupt pending logic.
module csr_file #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_vaddr,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] csr_rvalue,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int
);

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;
  localparam logic [TIMER_W-1:0] TVAL_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [8:0]         crmd_q, crmd_d;
  logic [2:0]         prmd_q, prmd_d;
  logic [12:0]        ecfg_q, ecfg_d;
  logic [1:0]         is_sw_q, is_sw_d;
  logic [7:0]         is_hw_q, is_hw_d;
  logic               is_timer_q, is_timer_d;
  logic               is_ipi_q, is_ipi_d;
  logic [5:0]         ecode_q, ecode_d;
  logic [8:0]         esub_q, esub_d;
  logic [31:0]        era_q, era_d;
  logic [31:0]        badv_q, badv_d;
  logic [25:0]        eentry_q, eentry_d;
  logic [31:0]        save_q [4];
  logic [31:0]        save_d [4];
  logic [31:0]        tid_q, tid_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;

  logic [31:0] estat;
  logic [31:0] wr_val;
  logic        tcfg_set;
  logic        ticlr;
  logic        timer_fire;
  logic        unused_csr_re;

  assign unused_csr_re = csr_re;
  assign estat = {1'b0, esub_q, ecode_q, 3'b000, is_ipi_q, is_timer_q, 1'b0, is_hw_q, is_sw_q};

  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = {23'h0, crmd_q};
      CSR_PRMD:   csr_rvalue = {29'h0, prmd_q};
      CSR_ECFG:   csr_rvalue = {19'h0, ecfg_q};
      CSR_ESTAT:  csr_rvalue = estat;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_BADV:   csr_rvalue = badv_q;
      CSR_EENTRY: csr_rvalue = {eentry_q, 6'h0};
      CSR_SAVE0:  csr_rvalue = save_q[0];
      CSR_SAVE1:  csr_rvalue = save_q[1];
      CSR_SAVE2:  csr_rvalue = save_q[2];
      CSR_SAVE3:  csr_rvalue = save_q[3];
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = 32'(tcfg_q);
      CSR_TVAL:   csr_rvalue = 32'(tval_q);
      default:    csr_rvalue = 32'h0;
    endcase
  end

  // The readback of the addressed CSR is the "old" value for the masked merge;
  // non-writable bits are dropped when each field is picked out below.
  assign wr_val = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);

  always_comb begin
    crmd_d     = crmd_q;
    prmd_d     = prmd_q;
    ecfg_d     = ecfg_q;
    is_sw_d    = is_sw_q;
    is_hw_d    = hw_int_in;
    is_timer_d = is_timer_q;
    is_ipi_d   = ipi_int_in;
    ecode_d    = ecode_q;
    esub_d     = esub_q;
    era_d      = era_q;
    badv_d     = badv_q;
    eentry_d   = eentry_q;
    save_d     = save_q;
    tid_d      = tid_q;
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    tcfg_set   = 1'b0;
    ticlr      = 1'b0;
    timer_fire = 1'b0;

    if (wb_ex) begin
      prmd_d         = crmd_q[2:0];
      crmd_d[2:0]    = 3'b000;
      era_d          = wb_pc;
      ecode_d        = wb_ecode;
      esub_d         = wb_esubcode;
      if (wb_ecode == 6'h08 || wb_ecode == 6'h09) badv_d = wb_vaddr;
    end else if (ertn_flush) begin
      crmd_d[2:0] = prmd_q;
    end else if (csr_we) begin
      case (csr_num)
        CSR_CRMD:   crmd_d    = wr_val[8:0];
        CSR_PRMD:   prmd_d    = wr_val[2:0];
        CSR_ECFG:   ecfg_d    = wr_val[12:0] & 13'h1BFF;
        CSR_ESTAT:  is_sw_d   = wr_val[1:0];
        CSR_ERA:    era_d     = wr_val;
        CSR_BADV:   badv_d    = wr_val;
        CSR_EENTRY: eentry_d  = wr_val[31:6];
        CSR_SAVE0:  save_d[0] = wr_val;
        CSR_SAVE1:  save_d[1] = wr_val;
        CSR_SAVE2:  save_d[2] = wr_val;
        CSR_SAVE3:  save_d[3] = wr_val;
        CSR_TID:    tid_d     = wr_val;
        CSR_TCFG: begin
          tcfg_d   = wr_val[TIMER_W-1:0];
          tcfg_set = wr_val[0];
        end
        CSR_TICLR:  ticlr     = wr_val[0];
        default: ;
      endcase
    end

    if (tcfg_set) begin
      tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0] && tval_q != '0) begin
      tval_d     = tval_q - TVAL_ONE;
      timer_fire = (tval_q == TVAL_ONE);
    end else if (tcfg_q[0] && tcfg_q[1]) begin
      tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
    end

    // A timer expiry in the same cycle as a TICLR clear keeps the interrupt.
    if (timer_fire) is_timer_d = 1'b1;
    else if (ticlr) is_timer_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_q     <= 9'h008;
      prmd_q     <= '0;
      ecfg_q     <= '0;
      is_sw_q    <= '0;
      is_hw_q    <= '0;
      is_timer_q <= 1'b0;
      is_ipi_q   <= 1'b0;
      ecode_q    <= '0;
      esub_q     <= '0;
      era_q      <= '0;
      badv_q     <= '0;
      eentry_q   <= '0;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
      tid_q      <= '0;
      tcfg_q     <= '0;
      tval_q     <= '1;
    end else begin
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      ecfg_q     <= ecfg_d;
      is_sw_q    <= is_sw_d;
      is_hw_q    <= is_hw_d;
      is_timer_q <= is_timer_d;
      is_ipi_q   <= is_ipi_d;
      ecode_q    <= ecode_d;
      esub_q     <= esub_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      eentry_q   <= eentry_d;
      save_q     <= save_d;
      tid_q      <= tid_d;
      tcfg_q     <= tcfg_d;
      tval_q     <= tval_d;
    end
  end

  assign ex_entry   = {eentry_q, 6'h0};
  assign ertn_entry = era_q;
  assign has_int    = crmd_q[2] & |(estat[12:0] & ecfg_q);

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus randomized traffic checked against
// an address-indexed register model.
`timescale 1ns/100ps
module tb_csr_file;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_re = 1'b0;
  logic [13:0] csr_num = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_wvalue = '0;
  logic        wb_ex = 1'b0;
  logic        ertn_flush = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [5:0]  wb_ecode = '0;
  logic [8:0]  wb_esubcode = '0;
  logic [31:0] wb_vaddr = '0;
  logic [7:0]  hw_int_in = '0;
  logic        ipi_int_in = 1'b0;
  logic [31:0] csr_rvalue, ex_entry, ertn_entry;
  logic        has_int;

  csr_file #(.TIMER_W(32)) dut (
    .clk(clk), .rst(rst), .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .csr_rvalue(csr_rvalue),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
  );

  always #5 clk = ~clk;

  localparam int A_CRMD = 'h00, A_PRMD = 'h01, A_ECFG = 'h04, A_ESTAT = 'h05, A_ERA = 'h06;
  localparam int A_BADV = 'h07, A_EENTRY = 'h0C, A_TID = 'h40, A_TCFG = 'h41;
  localparam int A_TVAL = 'h42, A_TICLR = 'h44;

  int errors = 0;
  int checks = 0;
  logic [31:0] m [0:68];

  function automatic logic [31:0] wmask_of(input logic [13:0] n);
    case (n)
      14'h00: return 32'h0000_01FF;
      14'h01: return 32'h0000_0007;
      14'h04: return 32'h0000_1BFF;
      14'h05: return 32'h0000_0003;
      14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: return 32'hFFFF_FFFF;
      14'h0C: return 32'hFFFF_FFC0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [13:0] n);
    case (n)
      14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C,
      14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42: return m[n];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_has_int();
    logic [31:0] pend;
    pend = m[A_ESTAT] & m[A_ECFG];
    return m[A_CRMD][2] & (pend[12:0] != 13'h0);
  endfunction

  // Advances the model by one clock using the inputs currently applied, then the DUT.
  task automatic step();
    logic [31:0] nx [0:68];
    logic [31:0] wm, wv;
    logic set_ld, clr, fire;
    nx = m; set_ld = 0; clr = 0; fire = 0;
    if (rst) begin
      foreach (nx[i]) nx[i] = 32'h0;
      nx[A_CRMD] = 32'h8;
      nx[A_TVAL] = 32'hFFFF_FFFF;
    end else begin
      nx[A_ESTAT][9:2] = hw_int_in;
      nx[A_ESTAT][12]  = ipi_int_in;
      if (wb_ex) begin
        nx[A_PRMD][2:0]    = m[A_CRMD][2:0];
        nx[A_CRMD][2:0]    = 3'b000;
        nx[A_ERA]          = wb_pc;
        nx[A_ESTAT][21:16] = wb_ecode;
        nx[A_ESTAT][30:22] = wb_esubcode;
        if (wb_ecode == 6'h08 || wb_ecode == 6'h09) nx[A_BADV] = wb_vaddr;
      end else if (ertn_flush) begin
        nx[A_CRMD][2:0] = m[A_PRMD][2:0];
      end else if (csr_we) begin
        wm = wmask_of(csr_num) & csr_wmask;
        wv = csr_wvalue & csr_wmask;
        if (wm != 0) nx[csr_num] = (nx[csr_num] & ~wm) | (wv & wm);
        if (csr_num == A_TICLR && wv[0]) clr = 1;
        if (csr_num == A_TCFG && nx[A_TCFG][0]) set_ld = 1;
      end
      if (set_ld) nx[A_TVAL] = {nx[A_TCFG][31:2], 2'b00};
      else if (m[A_TCFG][0] && m[A_TVAL] != 0) begin
        nx[A_TVAL] = m[A_TVAL] - 1;
        fire = (m[A_TVAL] == 1);
      end else if (m[A_TCFG][0] && m[A_TCFG][1]) nx[A_TVAL] = {m[A_TCFG][31:2], 2'b00};
      if (fire) nx[A_ESTAT][11] = 1'b1;
      else if (clr) nx[A_ESTAT][11] = 1'b0;
    end
    @(posedge clk); #1;
    m = nx;
    csr_we = 0; wb_ex = 0; ertn_flush = 0;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] mask, input logic [31:0] val);
    csr_num = n; csr_wmask = mask; csr_wvalue = val; csr_we = 1;
    step();
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] v);
    csr_num = n; #0.2; v = csr_rvalue;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    rd(A_CRMD, v);  checks++; if (v !== 32'h8) begin errors++; $display("FAIL reset_crmd got=%h exp=%h", v, 32'h8); end
    rd(A_TVAL, v);  checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_tval got=%h exp=ffffffff", v); end
    rd(A_ESTAT, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_estat got=%h exp=0", v); end
    checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL reset_has_int got=%b exp=0", has_int); end
    checks++; if (ex_entry !== 32'h0 || ertn_entry !== 32'h0) begin
      errors++; $display("FAIL reset_entries got=%h/%h exp=0/0", ex_entry, ertn_entry); end
  endtask

  task automatic test_masked_write();
    logic [31:0] v;
    wr(A_EENTRY, 32'hFFFF_FFFF, 32'h1C00_FFFF);
    rd(A_EENTRY, v); checks++; if (v !== 32'h1C00_FFC0) begin errors++; $display("FAIL eentry_read got=%h exp=1c00ffc0", v); end
    checks++; if (ex_entry !== 32'h1C00_FFC0) begin errors++; $display("FAIL ex_entry got=%h exp=1c00ffc0", ex_entry); end
    wr(14'h31, 32'hFFFF_FFFF, 32'h1234_5678);
    wr(14'h31, 32'h0000_FFFF, 32'hAAAA_5555);
    rd(14'h31, v); checks++; if (v !== 32'h1234_5555) begin errors++; $display("FAIL save1_masked got=%h exp=12345555", v); end
    wr(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(A_ECFG, v); checks++; if (v !== 32'h0000_1BFF) begin errors++; $display("FAIL ecfg_fields got=%h exp=00001bff", v); end
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h0);
    wr(14'h123, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h123, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", v); end
    rd(A_TICLR, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL ticlr_read got=%h exp=0", v); end
  endtask

  task automatic test_exception_ertn();
    logic [31:0] v;
    wr(A_CRMD, 32'h7, 32'h7);
    rd(A_CRMD, v); checks++; if (v !== 32'hF) begin errors++; $display("FAIL crmd_plv_ie got=%h exp=f", v); end
    wb_ex = 1; wb_pc = 32'h1C00_0100; wb_ecode = 6'h09; wb_esubcode = 9'h015; wb_vaddr = 32'h1001;
    step();
    rd(A_PRMD, v);  checks++; if (v !== 32'h7) begin errors++; $display("FAIL ex_prmd got=%h exp=7", v); end
    rd(A_CRMD, v);  checks++; if (v !== 32'h8) begin errors++; $display("FAIL ex_crmd got=%h exp=8", v); end
    rd(A_ERA, v);   checks++; if (v !== 32'h1C00_0100) begin errors++; $display("FAIL ex_era got=%h exp=1c000100", v); end
    rd(A_ESTAT, v); checks++; if (v[30:16] !== {9'h015, 6'h09}) begin
      errors++; $display("FAIL ex_estat_code got=%h exp=%h", v[30:16], {9'h015, 6'h09}); end
    rd(A_BADV, v);  checks++; if (v !== 32'h1001) begin errors++; $display("FAIL ex_badv got=%h exp=1001", v); end
    ertn_flush = 1; #0.2;
    checks++; if (ertn_entry !== 32'h1C00_0100) begin errors++; $display("FAIL ertn_entry got=%h exp=1c000100", ertn_entry); end
    step();
    rd(A_CRMD, v); checks++; if (v !== 32'hF) begin errors++; $display("FAIL ertn_crmd got=%h exp=f", v); end
  endtask

  task automatic test_ex_suppress();
    logic [31:0] v;
    wr(14'h30, 32'hFFFF_FFFF, 32'h1111_1111);
    wb_ex = 1; wb_pc = 32'h1C00_0200; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_vaddr = 32'hBAD;
    csr_we = 1; csr_num = 14'h30; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'hDEAD_BEEF;
    step();
    rd(14'h30, v); checks++; if (v !== 32'h1111_1111) begin errors++; $display("FAIL sup_save0 got=%h exp=11111111", v); end
    rd(A_BADV, v); checks++; if (v !== 32'h1001) begin errors++; $display("FAIL sup_badv got=%h exp=1001", v); end
    rd(A_ERA, v);  checks++; if (v !== 32'h1C00_0200) begin errors++; $display("FAIL sup_era got=%h exp=1c000200", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v, e;
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h800);
    wr(A_CRMD, 32'h7, 32'h4);
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
    for (int exp_tv = 8; exp_tv >= 0; exp_tv--) begin
      rd(A_TVAL, v); checks++; if (v !== 32'(exp_tv)) begin errors++; $display("FAIL tval_count got=%0d exp=%0d", v, exp_tv); end
      rd(A_ESTAT, e); checks++; if (e[11] !== (exp_tv == 0)) begin
        errors++; $display("FAIL timer_is11 tval=%0d got=%b exp=%b", exp_tv, e[11], exp_tv == 0); end
      if (exp_tv == 1) wr(A_TICLR, 32'h1, 32'h1);
      else if (exp_tv != 0) step();
    end
    checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL timer_has_int got=%b exp=1", has_int); end
    step();
    rd(A_TVAL, v); checks++; if (v !== 32'h8) begin errors++; $display("FAIL tval_reload got=%h exp=8", v); end
    wr(A_TICLR, 32'hFFFF_FFFF, 32'h1);
    rd(A_ESTAT, e); checks++; if (e[11] !== 1'b0 || has_int !== 1'b0) begin
      errors++; $display("FAIL ticlr_clear got=%b/%b exp=0/0", e[11], has_int); end
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
    for (int i = 0; i < 7; i++) step();
    rd(A_TVAL, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL oneshot_tval got=%h exp=0", v); end
    wr(A_TICLR, 32'h1, 32'h1);
    for (int i = 0; i < 4; i++) step();
    rd(A_ESTAT, e); checks++; if (e[11] !== 1'b0) begin errors++; $display("FAIL oneshot_refire got=%b exp=0", e[11]); end
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
    step();
    do_reset();
    rd(A_TVAL, v); checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_midcount got=%h exp=ffffffff", v); end
  endtask

  task automatic test_hw_int();
    logic [31:0] v;
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h10);
    wr(A_CRMD, 32'h7, 32'h4);
    hw_int_in = 8'h04; #0.2;
    checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL hw_int_latency got=%b exp=0", has_int); end
    step();
    rd(A_ESTAT, v); checks++; if (v[4] !== 1'b1) begin errors++; $display("FAIL hw_is4 got=%b exp=1", v[4]); end
    checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL hw_has_int got=%b exp=1", has_int); end
    hw_int_in = 8'h00;
    step();
    checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL hw_deassert got=%b exp=0", has_int); end
  endtask

  task automatic test_random();
    logic [13:0] pool [16];
    logic [31:0] v, e;
    int r;
    pool = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C, 14'h30,
             14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h123};
    do_reset();
    for (int it = 0; it < 300; it++) begin
      for (int k = 0; k < 16; k++) begin
        rd(pool[k], v); e = mread(pool[k]);
        checks++; if (v !== e) begin errors++; $display("FAIL rand_read it=%0d addr=%h got=%h exp=%h", it, pool[k], v, e); end
      end
      checks++; if (ex_entry !== {m[A_EENTRY][31:6], 6'h0} || ertn_entry !== m[A_ERA] || has_int !== m_has_int()) begin
        errors++; $display("FAIL rand_outputs it=%0d got=%h/%h/%b exp=%h/%h/%b", it, ex_entry, ertn_entry, has_int,
                           {m[A_EENTRY][31:6], 6'h0}, m[A_ERA], m_has_int()); end
      if ($urandom_range(0, 3) == 0) hw_int_in = 8'($urandom);
      ipi_int_in = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      wb_ex = (r == 0);
      ertn_flush = (r == 1);
      wb_pc = $urandom; wb_vaddr = $urandom; wb_esubcode = 9'($urandom);
      case ($urandom_range(0, 3))
        0: wb_ecode = 6'h08; 1: wb_ecode = 6'h09; 2: wb_ecode = 6'h0B; default: wb_ecode = 6'($urandom);
      endcase
      csr_we = ($urandom_range(0, 3) != 0);
      csr_num = pool[$urandom_range(0, 15)];
      if (csr_num == 14'h41) csr_num = 14'h30;
      csr_wmask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
      csr_wvalue = $urandom;
      step();
    end
    hw_int_in = 0; ipi_int_in = 0;
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_exception_ertn();
    test_ex_suppress();
    test_timer();
    test_hw_int();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
